// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: turns pipeline load/store requests into
// single-word memory transactions, stalls the pipeline while the access is
// outstanding, sizes and extends load data, and flags misalignment/timeouts.
module dm_access_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // pipeline side
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        BeOP,
  input  logic [2:0]        MeOP,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata_out,
  output logic              rdata_valid,
  output logic              misalign,
  output logic              bus_err,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [29:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CntW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] wait_q;
  logic            we_q;
  logic            load_q;
  logic [2:0]      ld_op_q;
  logic [1:0]      off_q;
  logic [3:0]      mem_be_q;
  logic [29:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;

  logic        access;
  logic        mis;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ext_d;

  assign access = MemWrite | MemRead;

  // Alignment check; a store takes priority over a load when both are requested.
  always_comb begin
    mis = 1'b0;
    if (MemWrite) begin
      mis = ((BeOP == 2'b10) && addr[0]) || ((BeOP == 2'b11) && (addr[1:0] != 2'b00));
    end else if (MemRead) begin
      mis = (((MeOP == 3'b011) || (MeOP == 3'b100)) && addr[0]) ||
            ((MeOP == 3'b101) && (addr[1:0] != 2'b00));
    end
  end

  // Byte enables and lane-replicated store data for the request about to launch.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = wdata;
    if (MemWrite) begin
      case (BeOP)
        2'b01: begin
          be_d    = 4'b0001 << addr[1:0];
          wdata_d = {4{wdata[7:0]}};
        end
        2'b10: begin
          be_d    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{wdata[15:0]}};
        end
        2'b11:   be_d = 4'b1111;
        default: be_d = 4'b0000;
      endcase
    end
  end

  // Little-endian extraction and extension of the returned word.
  always_comb begin
    logic [31:0] shifted;
    logic [15:0] half;
    shifted = mem_rdata >> {off_q, 3'b000};
    half    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_op_q)
      3'b001:  ext_d = {{24{shifted[7]}}, shifted[7:0]};
      3'b010:  ext_d = {24'h0, shifted[7:0]};
      3'b011:  ext_d = {{16{half[15]}}, half};
      3'b100:  ext_d = {16'h0, half};
      default: ext_d = mem_rdata;
    endcase
  end

  // Pipeline handshake: stall/misalign answer the current request in IDLE without waiting a cycle.
  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    case (state_q)
      StIdle: begin
        stall    = rst_n & access & ~mis;
        misalign = rst_n & access & mis;
      end
      StReq:   stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  assign mem_req   = (state_q == StReq);
  assign mem_we    = mem_req & we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Access FSM: latch the request in IDLE, wait for ack or timeout in REQ, report in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      we_q        <= 1'b0;
      load_q      <= 1'b0;
      ld_op_q     <= 3'b000;
      off_q       <= 2'b00;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_out   <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (access && !mis) begin
            state_q     <= StReq;
            wait_q      <= '0;
            we_q        <= MemWrite;
            load_q      <= MemRead & ~MemWrite;
            ld_op_q     <= MeOP;
            off_q       <= addr[1:0];
            mem_be_q    <= be_d;
            mem_addr_q  <= 30'(addr >> 2);
            mem_wdata_q <= wdata_d;
          end
        end
        StReq: begin
          if (mem_ack) begin
            state_q <= StDone;
            bus_err <= 1'b0;
            if (load_q) begin
              rdata_out   <= ext_d;
              rdata_valid <= 1'b1;
            end
          end else if (wait_q == CntW'(MAX_WAIT - 1)) begin
            state_q   <= StDone;
            bus_err   <= 1'b1;
            rdata_out <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          bus_err     <= 1'b0;
          rdata_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Randomized bench for dm_access_ctrl: each transaction is scored against a
// per-access model computed from access size, address offset and ack timing.
module tb_dm_access_ctrl;

  localparam int unsigned MaxWait = 15;

  logic        clk;
  logic        rst_n;
  logic        MemWrite;
  logic        MemRead;
  logic [1:0]  BeOP;
  logic [2:0]  MeOP;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_vec;
  int n_err;
  logic [31:0] exp_rdata;

  dm_access_ctrl #(.MAX_WAIT(MaxWait), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .BeOP       (BeOP),
    .MeOP       (MeOP),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata_out  (rdata_out),
    .rdata_valid(rdata_valid),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access size in bytes from the opcode; 0 means no sized access.
  function automatic int size_of(input bit wr, input bit [1:0] be_op, input bit [2:0] me_op);
    if (wr) return (be_op == 1) ? 1 : (be_op == 2) ? 2 : (be_op == 3) ? 4 : 0;
    case (me_op)
      1, 2:    return 1;
      3, 4:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input bit [2:0] me_op, input int a,
                                             input logic [31:0] word);
    int unsigned b, h;
    b = (word >> (8 * (a % 4))) & 32'hFF;
    h = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (me_op)
      1:       return (b >= 128) ? (b + 32'hFFFFFF00) : b;
      2:       return b;
      3:       return (h >= 32768) ? (h + 32'hFFFF0000) : h;
      4:       return h;
      default: return word;
    endcase
  endfunction

  // Runs one access from IDLE; ack_at is the 1-based REQ cycle carrying mem_ack (> MaxWait: never).
  task automatic run_access(input bit wr, input bit rd, input bit [1:0] be_op,
                            input bit [2:0] me_op, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rword,
                            input int ack_at, input bit back2back);
    int sz, off;
    bit is_load, mis, acked;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    sz      = size_of(wr, be_op, me_op);
    off     = a % 4;
    is_load = rd && !wr;
    mis     = (sz > 1) && ((off % sz) != 0);
    if (!wr)          exp_be = 4'hF;
    else if (sz == 1) exp_be = 4'(1 << off);
    else if (sz == 2) exp_be = (off >= 2) ? 4'hC : 4'h3;
    else              exp_be = 4'hF;
    if (wr && sz == 1)      exp_wd = {4{wd[7:0]}};
    else if (wr && sz == 2) exp_wd = {2{wd[15:0]}};
    else                    exp_wd = wd;

    MemWrite = wr; MemRead = rd; BeOP = be_op; MeOP = me_op; addr = a; wdata = wd;
    @(negedge clk);
    check("idle_misalign", 32'(misalign), 32'(mis));
    check("idle_stall", 32'(stall), 32'(!mis));
    check("idle_mem_req", 32'(mem_req), 0);
    if (mis) begin
      @(posedge clk); #1;
      MemWrite = 0; MemRead = 0;
      @(negedge clk);
      check("mis_no_req", 32'(mem_req), 0);
      check("mis_cleared", 32'(misalign), 0);
      @(posedge clk); #1;
      return;
    end

    acked = 0;
    for (int k = 1; k <= int'(MaxWait); k++) begin
      @(posedge clk); #1;
      mem_ack = (k == ack_at); mem_rdata = rword;
      @(negedge clk);
      check("req_mem_req", 32'(mem_req), 1);
      check("req_stall", 32'(stall), 1);
      check("req_we", 32'(mem_we), 32'(wr));
      check("req_be", 32'(mem_be), 32'(exp_be));
      check("req_wdata", mem_wdata, exp_wd);
      check("req_addr", 32'(mem_addr), a >> 2);
      if (k == ack_at) begin
        acked = 1;
        break;
      end
    end

    @(posedge clk); #1;
    mem_ack = 0; MemWrite = 0; MemRead = 0;
    if (!acked)       exp_rdata = 0;
    else if (is_load) exp_rdata = load_value(me_op, a, rword);
    @(negedge clk);
    check("done_stall", 32'(stall), 0);
    check("done_mem_req", 32'(mem_req), 0);
    check("done_bus_err", 32'(bus_err), 32'(!acked));
    check("done_valid", 32'(rdata_valid), 32'(acked && is_load));
    check("done_rdata", rdata_out, exp_rdata);
    @(posedge clk); #1;
    if (back2back) return;

    mem_ack = $urandom_range(0, 1);  // ack outside REQ must be ignored
    @(negedge clk);
    check("post_stall", 32'(stall), 0);
    check("post_req", 32'(mem_req), 0);
    check("post_valid", 32'(rdata_valid), 0);
    check("post_bus_err", 32'(bus_err), 0);
    check("post_rdata", rdata_out, exp_rdata);
    @(posedge clk); #1;
    mem_ack = 0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_rdata = 0;
    rst_n = 0; MemWrite = 0; MemRead = 0; BeOP = 0; MeOP = 0;
    addr = 0; wdata = 0; mem_rdata = 0; mem_ack = 0;
    #12;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_mem_be", 32'(mem_be), 0);
    check("rst_rdata", rdata_out, 0);
    check("rst_flags", {28'h0, rdata_valid, misalign, bus_err, mem_we}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Directed cases from the known-answer list.
    run_access(1, 0, 2'b01, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 2, 0);
    run_access(0, 1, 2'b00, 3'b001, 32'h2002, 32'h0, 32'h12F03456, 1, 0);
    check("lb_value", rdata_out, 32'hFFFFFFF0);
    run_access(0, 1, 2'b00, 3'b010, 32'h2002, 32'h0, 32'h12F03456, 3, 0);
    check("lbu_value", rdata_out, 32'h000000F0);
    run_access(0, 1, 2'b00, 3'b100, 32'h2002, 32'h0, 32'h12F03456, 1, 0);
    check("lhu_value", rdata_out, 32'h000012F0);
    run_access(0, 1, 2'b00, 3'b101, 32'h3001, 32'h0, 32'h0, 1, 0);
    run_access(0, 1, 2'b00, 3'b101, 32'h3000, 32'h0, 32'h55AA55AA, 99, 0);
    run_access(0, 1, 2'b00, 3'b101, 32'h3000, 32'h0, 32'h55AA55AA, 15, 0);
    run_access(1, 1, 2'b10, 3'b101, 32'h0102, 32'hCAFE1234, 32'h11111111, 4, 1);
    run_access(0, 1, 2'b00, 3'b011, 32'h0106, 32'h0, 32'h8001FFFF, 1, 0);

    // Reset asserted while waiting on memory aborts the access at once.
    MemWrite = 0; MemRead = 1; MeOP = 3'b101; addr = 32'h500; wdata = 0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("abort_mem_req", 32'(mem_req), 0);
    check("abort_stall", 32'(stall), 0);
    check("abort_mem_be", 32'(mem_be), 0);
    check("abort_rdata", rdata_out, 0);
    MemRead = 0; exp_rdata = 0;
    #4;
    rst_n = 1;
    @(posedge clk); #1;
    run_access(1, 0, 2'b11, 3'b000, 32'h40, 32'hDEADBEEF, 32'h0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 200; i++) begin
      bit wr, rd;
      int sel;
      sel = $urandom_range(0, 9);
      wr  = (sel < 4) || (sel == 9);
      rd  = (sel >= 4);
      run_access(wr, rd, 2'($urandom_range(1, 3)), 3'($urandom_range(1, 5)),
                 $urandom & 32'h0000FFFF, $urandom, $urandom,
                 $urandom_range(1, 18), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
